adder_result_checker: RTL and testbench
=======================================

Name: adder_result_checker

Overview:
Synthesizable self-checking monitor for the 16-bit Brent-Kung adder.
- Reads the operands driven into the adder and the adder's sum/carry-out, recomputes the expected result with a bit-serial ripple adder, and compares.
- Keeps pass/error counts, so benches and on-chip BIST read a verdict instead of inspecting waveforms.
- Sits beside the adder on the consumer side of its result interface.

Parameters:
WIDTH, 16, operand/sum width in bits
CNT_W, 16, width of the saturating transaction and error counters

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and adder result presented this cycle
in_ready  output  1  checker idle and able to accept
a  input  WIDTH  operand A as driven into the adder
b  input  WIDTH  operand B as driven into the adder
cin  input  1  carry-in as driven into the adder
dut_sum  input  WIDTH  adder sum output
dut_co  input  1  adder carry-out
clr_counts  input  1  synchronous clear of both counters
done  output  1  one-cycle pulse: verdict valid
pass  output  1  last verdict, 1 = match
exp_sum  output  WIDTH  last expected sum
exp_co  output  1  last expected carry-out
chk_count  output  CNT_W  transactions checked (saturating)
err_count  output  CNT_W  mismatches (saturating)

Behaviour:
- Reset is asynchronous and active-low: clk/rst_n, async assert, sync release.
- On reset: state IDLE and every output 0, including in_ready. in_ready becomes 1 in the first cycle after reset release.
- in_ready = (state == IDLE), combinational from the state register.
- Accept on the edge where in_valid && in_ready (edge E0). Latch a, b, cin, dut_sum, dut_co. Bit index = 0, carry = cin. Go to SHIFT.
- While busy, in_valid is ignored and inputs are not sampled. Inputs may change freely after E0.
- SHIFT, edges E1..E_WIDTH:
  - bit i: s = a[i]^b[i]^c; c' = majority(a[i], b[i], c).
  - s is shifted into the expected register MSB-first so the LSB lands at bit 0.
  - At E_WIDTH go to CMP.
- CMP, edge E_(WIDTH+1):
  - exp_sum/exp_co update.
  - pass = ({exp_co, exp_sum} == {dut_co, dut_sum}).
  - done = 1 for exactly one cycle.
  - chk_count += 1; err_count += 1 if mismatch.
  - Go to IDLE.
- Latency: done is high in the cycle after E_(WIDTH+1), i.e. WIDTH+1 edges after acceptance. Throughput: one check per WIDTH+2 cycles.
- pass, exp_sum and exp_co hold their values until the next CMP.
- Counters saturate at all-ones and never wrap.
- clr_counts zeroes both counters on the next edge. If it coincides with a CMP update, clear wins and the concurrent result is not counted; done/pass still update.
- Reset mid-SHIFT or mid-CMP aborts the check: no done, counters cleared.
- Carry arithmetic is exact at WIDTH+1 bits. Full wrap case: 0xFFFF + 0xFFFF + 1 gives sum 0xFFFF, co 1.

Decomposition:
- Package adder_chk_pkg: state enum {IDLE, SHIFT, CMP}, default WIDTH/CNT_W constants, bit-index width as $clog2(WIDTH).
- One natural sub-module, serial_adder_bit: 1-bit full adder with carry flop, load, and enable.
- FSM, shift register and counters stay in the top.

Test Plan:
- a=6500, b=25000, cin=0, dut_sum=31500, dut_co=0 -> done 17 cycles after accept; pass=1, exp_sum=31500, chk_count=1, err_count=0.
- a=55000, b=25, dut_sum=55025, dut_co=0, then a=0x7FFF, b=0x7FFF, dut_sum=0xFFFE, dut_co=0 -> both pass=1; chk_count=2.
- a=0xFFFF, b=0xFFFF, cin=1, dut_sum=0xFFFF, dut_co=1 -> pass=1, exp_co=1. Repeat with dut_co=0 -> pass=0, err_count=1.
- in_valid held high continuously -> in_ready low for 17 cycles after each accept; no sample taken while busy; exactly one done per accept.
- rst_n pulsed low at SHIFT bit 7 -> outputs 0 immediately, no done; next transaction checks correctly.
- With CNT_W=2: 5 mismatching checks -> err_count stays 3. clr_counts on the same edge as a CMP -> both counters 0, done still pulses.

Source files
------------

// File: rtl/adder_chk_pkg.sv
// adder_chk_pkg: shared state encoding and defaults for the adder result checker
package adder_chk_pkg;
  localparam int WIDTH_D = 16;
  localparam int CNT_W_D = 16;
  typedef enum logic [1:0] {IDLE, SHIFT, CMP} state_t;
  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/serial_adder_bit.sv
// serial_adder_bit: one-bit full adder whose carry is held in a flop between bits
module serial_adder_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  input  logic cin,
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b ^ c;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) c <= 1'b0;
    else if (load) c <= cin;
    else if (en) c <= (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/adder_result_checker.sv
// adder_result_checker: recomputes an adder result bit-serially and keeps pass/error counts
module adder_result_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_co,
  input  logic             clr_counts,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] exp_sum,
  output logic             exp_co,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count
);
  localparam int IW = idx_w(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_r, b_r, sum_r, acc;
  logic co_r, s, c, accept, last, match;
  logic [IW-1:0] idx;
  assign in_ready = rst_n && state == IDLE;
  assign accept = in_valid && in_ready;
  assign last = idx == IW'(WIDTH - 1);
  assign match = {c, acc} == {co_r, sum_r};
  always_comb
    state_nx = state == IDLE ? (in_valid ? SHIFT : IDLE) :
               state == SHIFT ? (last ? CMP : SHIFT) : IDLE;
  serial_adder_bit u_bit (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept),
    .en   (state == SHIFT),
    .cin  (cin),
    .a    (a_r[idx]),
    .b    (b_r[idx]),
    .s    (s),
    .c    (c)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      sum_r     <= '0;
      co_r      <= 1'b0;
      acc       <= '0;
      idx       <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      exp_sum   <= '0;
      exp_co    <= 1'b0;
      chk_count <= '0;
      err_count <= '0;
    end else begin
      state <= state_nx;
      done  <= state == CMP;
      if (accept) begin
        a_r   <= a;
        b_r   <= b;
        sum_r <= dut_sum;
        co_r  <= dut_co;
        idx   <= '0;
      end
      // sum bits enter at the MSB so bit 0 ends at the bottom after WIDTH shifts
      if (state == SHIFT) begin
        acc <= {s, acc[WIDTH-1:1]};
        idx <= idx + 1'b1;
      end
      if (state == CMP) begin
        exp_sum <= acc;
        exp_co  <= c;
        pass    <= match;
      end
      if (clr_counts) begin
        chk_count <= '0;
        err_count <= '0;
      end else if (state == CMP) begin
        chk_count <= chk_count + CNT_W'(~&chk_count);
        err_count <= err_count + CNT_W'(!match && !(&err_count));
      end
    end
endmodule

// File: tb/tb_adder_result_checker.sv
// tb_adder_result_checker: directed checks against an arithmetic reference model
module tb_adder_result_checker;
  localparam int W = 16;
  logic clk = 0, rst_n = 0, in_valid = 0, cin = 0, dut_co = 0, clr_counts = 0;
  logic [W-1:0] a = 0, b = 0, dut_sum = 0;
  logic in_ready, done, pass, exp_co;
  logic [W-1:0] exp_sum, chk_count, err_count;
  logic in_ready2, done2, pass2, exp_co2;
  logic [W-1:0] exp_sum2;
  logic [1:0] chk2, err2;
  int n_chk = 0, n_fail = 0;

  adder_result_checker dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .dut_sum(dut_sum), .dut_co(dut_co),
    .clr_counts(clr_counts), .done(done), .pass(pass), .exp_sum(exp_sum),
    .exp_co(exp_co), .chk_count(chk_count), .err_count(err_count)
  );
  adder_result_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .cin(cin), .dut_sum(dut_sum), .dut_co(dut_co),
    .clr_counts(clr_counts), .done(done2), .pass(pass2), .exp_sum(exp_sum2),
    .exp_co(exp_co2), .chk_count(chk2), .err_count(err2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // reference: result = a+b+cin at WIDTH+1 bits, verdict WIDTH+1 edges after accept
  int m_left = 0, m_chk = 0, m_err = 0, m_chk2 = 0, m_err2 = 0;
  logic [W:0] m_res = 0, m_dut = 0;
  logic m_done = 0, m_pass = 0, m_co = 0;
  logic [W-1:0] m_sum = 0;

  function automatic int sat(input int v, input int mx);
    return v < mx ? v + 1 : mx;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_left = 0; m_done = 0; m_pass = 0; m_sum = 0; m_co = 0;
      m_chk = 0; m_err = 0; m_chk2 = 0; m_err2 = 0;
    end else begin
      m_done = 0;
      if (m_left == 1) begin
        m_done = 1;
        m_pass = m_res == m_dut;
        {m_co, m_sum} = m_res;
        m_chk = sat(m_chk, 65535);
        m_chk2 = sat(m_chk2, 3);
        if (!m_pass) begin
          m_err = sat(m_err, 65535);
          m_err2 = sat(m_err2, 3);
        end
      end
      if (clr_counts) begin
        m_chk = 0; m_err = 0; m_chk2 = 0; m_err2 = 0;
      end
      if (m_left > 0) m_left--;
      else if (in_valid) begin
        m_res = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        m_dut = {dut_co, dut_sum};
        m_left = W + 1;
      end
    end

  always @(negedge clk) begin
    chk("in_ready", in_ready, (m_left == 0) && rst_n);
    chk("done", done, m_done);
    chk("pass", pass, m_pass);
    chk("exp_sum", exp_sum, m_sum);
    chk("exp_co", exp_co, m_co);
    chk("chk_count", chk_count, m_chk);
    chk("err_count", err_count, m_err);
    chk("done2", done2, m_done);
    chk("chk_count2", chk2, m_chk2);
    chk("err_count2", err2, m_err2);
  end

  task automatic xact(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input logic [W-1:0] ts, input logic tco, input bit clr, output int lat);
    int k = 0;
    while (!in_ready && k < 40) begin @(negedge clk); k++; end
    chk("ready_wait", in_ready, 1);
    a = ta; b = tb; cin = tc; dut_sum = ts; dut_co = tco; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    a = W'($urandom); b = W'($urandom); dut_sum = W'($urandom);
    cin = 1'($urandom); dut_co = 1'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      if (clr && lat == W) clr_counts = 1;
      @(negedge clk);
      lat++;
    end
    clr_counts = 0;
    chk("done_seen", done, 1);
  endtask

  initial begin
    int lat, nd;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_done", done, 0);
    #2 rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    xact(16'd6500, 16'd25000, 0, 16'd31500, 0, 0, lat);
    chk("latency", lat, 17);
    chk("sum1", exp_sum, 31500);
    chk("pass1", pass, 1);
    chk("cnt1", chk_count, 1);
    chk("err1", err_count, 0);
    xact(16'd55000, 16'd25, 0, 16'd55025, 0, 0, lat);
    chk("pass2", pass, 1);
    xact(16'h7FFF, 16'h7FFF, 0, 16'hFFFE, 0, 0, lat);
    chk("pass3", pass, 1);
    chk("cnt3", chk_count, 3);
    xact(16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 1, 0, lat);
    chk("wrap_pass", pass, 1);
    chk("wrap_co", exp_co, 1);
    chk("wrap_sum", exp_sum, 16'hFFFF);
    xact(16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 0, 0, lat);
    chk("wrap_bad_pass", pass, 0);
    chk("wrap_bad_err", err_count, 1);
    nd = 0;
    in_valid = 1;
    for (int i = 0; i < 54; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      {dut_co, dut_sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      @(negedge clk);
      if (done) nd++;
    end
    in_valid = 0;
    chk("streaming_dones", nd, 3);
    a = 16'd10; b = 16'd20; cin = 0; dut_sum = 16'd30; dut_co = 0; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (7) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_done", done, 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_cnt", chk_count, 0);
    chk("abort_sum", exp_sum, 0);
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    xact(16'd1234, 16'd4321, 1, 16'd5556, 0, 0, lat);
    chk("post_rst_pass", pass, 1);
    chk("post_rst_cnt", chk_count, 1);
    for (int i = 1; i <= 5; i++) xact(W'(i * 100), W'(i), 0, 16'd0, 1, 0, lat);
    chk("sat_err2", err2, 3);
    chk("sat_chk2", chk2, 3);
    chk("err16", err_count, 5);
    xact(16'd100, 16'd200, 0, 16'd300, 0, 1, lat);
    chk("clr_done", done, 1);
    chk("clr_pass", pass, 1);
    chk("clr_chk", chk_count, 0);
    chk("clr_err", err_count, 0);
    chk("clr_err2", err2, 0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
